// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types for the pipeline hazard controller.
//   state_e : controller FSM state (RUN, FLUSH, MEM_WAIT), 2-bit encoded
//   prio_e  : resolved hazard class for the current cycle (NONE, LU, BR, MEM)
//   resolve_prio() : fixed-priority arbitration mem_busy > branch > load-use
// -----------------------------------------------------------------------------
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        LU   = 2'd1,
        BR   = 2'd2,
        MEM  = 2'd3
    } prio_e;

    // Highest-priority hazard wins; lower classes are either held by the
    // frozen stages (under MEM) or irrelevant (wrong-path ID under BR).
    function automatic prio_e resolve_prio(input logic mem_busy,
                                           input logic branch_taken,
                                           input logic load_use);
        prio_e p;
        if (mem_busy) begin
            p = MEM;
        end else if (branch_taken) begin
            p = BR;
        end else if (load_use) begin
            p = LU;
        end else begin
            p = NONE;
        end
        return p;
    endfunction

endpackage

// File: rtl/hazard_sat_counter.sv
// -----------------------------------------------------------------------------
// hazard_sat_counter
// Parameterised-width up counter that sticks at all-ones.
//   clk_i : rising-edge clock
//   clr_i : synchronous clear (wins over inc_i)
//   inc_i : increment request for this cycle
//   cnt_o : current count
// -----------------------------------------------------------------------------
module hazard_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    localparam logic [W-1:0] CNT_MAX  = {W{1'b1}};
    localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
    localparam logic [W-1:0] CNT_ONE  = W'(1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = CNT_ZERO;
        end else if (inc_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Freeze/flush controller for a 5-stage pipeline. Resolves, by fixed priority,
// data-memory stalls (mem_busy), taken branches resolved in EX and load-use
// hazards, with an FSM for multi-cycle IF/ID flush windows and memory-wait
// timeout supervision. Control outputs are Mealy: decoded from the registered
// state and the current inputs.
//
// Optional feature macro: HAZARD_STATS_EN adds stall_cnt_o / flush_cnt_o
// (width `WORD_LEN, normally supplied by defines.v).
//
// Ports
//   clk_i, rst_i           : clock, synchronous active-high reset
//   id_src1_i, id_src2_i   : source registers of the ID instruction
//   id_use_src2_i          : ID instruction reads id_src2_i
//   ex_mem_read_i          : EX instruction is a load
//   ex_dest_i              : EX instruction destination register
//   branch_taken_i         : EX resolved a taken branch
//   mem_busy_i             : data memory not ready
//   *_freeze_o             : hold PC / pipe register
//   if_id_flush_o, id_ex_flush_o : load a bubble
//   mem_timeout_o          : sticky memory-wait timeout
//   stall_cnt_o, flush_cnt_o     : statistics (HAZARD_STATS_EN only)
// -----------------------------------------------------------------------------
`ifdef HAZARD_STATS_EN
`ifndef WORD_LEN
`define WORD_LEN 32
`endif
`endif

module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W   = 4,
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [REG_ADDR_W-1:0] id_src1_i,
    input  logic [REG_ADDR_W-1:0] id_src2_i,
    input  logic                  id_use_src2_i,
    input  logic                  ex_mem_read_i,
    input  logic [REG_ADDR_W-1:0] ex_dest_i,
    input  logic                  branch_taken_i,
    input  logic                  mem_busy_i,
    output logic                  pc_freeze_o,
    output logic                  if_id_freeze_o,
    output logic                  id_ex_freeze_o,
    output logic                  ex_mem_freeze_o,
    output logic                  mem_wb_freeze_o,
    output logic                  if_id_flush_o,
    output logic                  id_ex_flush_o,
    output logic                  mem_timeout_o
`ifdef HAZARD_STATS_EN
    ,
    output logic [`WORD_LEN-1:0]  stall_cnt_o,
    output logic [`WORD_LEN-1:0]  flush_cnt_o
`endif
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam int FL_W   = $clog2(FLUSH_CYCLES + 1);

    localparam logic [WAIT_W-1:0] WAIT_ZERO   = {WAIT_W{1'b0}};
    localparam logic [WAIT_W-1:0] WAIT_ONE    = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_MAX    = {WAIT_W{1'b1}};
    localparam logic [WAIT_W-1:0] TIMEOUT_VAL = WAIT_W'(MEM_TIMEOUT);

    localparam logic [FL_W-1:0] FL_ZERO   = {FL_W{1'b0}};
    localparam logic [FL_W-1:0] FL_ONE    = FL_W'(1);
    localparam logic [FL_W-1:0] FL_RELOAD = FL_W'(FLUSH_CYCLES - 1);

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = {REG_ADDR_W{1'b0}};

    state_e            state_q, state_d;
    state_e            eff_state_s;
    prio_e             prio_s;
    logic [FL_W-1:0]   flush_left_q, flush_left_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_timeout_q, mem_timeout_d;
    logic              lu_s;
    logic              branch_next_s;

    // Register 0 is hardwired, so a load targeting it never creates a hazard.
    assign lu_s = ex_mem_read_i && (ex_dest_i != REG_ZERO) &&
                  ((ex_dest_i == id_src1_i) ||
                   (id_use_src2_i && (ex_dest_i == id_src2_i)));

    // During the reset cycle the outputs decode as RUN regardless of state.
    assign eff_state_s = rst_i ? RUN : state_q;
    assign prio_s      = resolve_prio(mem_busy_i, branch_taken_i, lu_s);

    // A one-cycle window needs no FLUSH state: the branch cycle covers it.
    assign branch_next_s = (FL_RELOAD == FL_ZERO) ? 1'b0 : 1'b1;

    // State register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= RUN;
            flush_left_q  <= FL_ZERO;
            wait_cnt_q    <= WAIT_ZERO;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            flush_left_q  <= flush_left_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    // Next-state logic: flush window countdown and memory-wait supervision.
    always_comb begin
        state_d      = state_q;
        flush_left_d = flush_left_q;
        wait_cnt_d   = WAIT_ZERO;
        case (eff_state_s)
            FLUSH: begin
                case (prio_s)
                    MEM: begin
                        // Frozen: window holds, wait is not supervised here.
                        state_d      = FLUSH;
                        flush_left_d = flush_left_q;
                    end
                    BR: begin
                        flush_left_d = FL_RELOAD;
                        state_d      = branch_next_s ? FLUSH : RUN;
                    end
                    default: begin
                        // Load-use is ignored: the ID instruction is being flushed.
                        if (flush_left_q <= FL_ONE) begin
                            flush_left_d = FL_ZERO;
                            state_d      = RUN;
                        end else begin
                            flush_left_d = flush_left_q - FL_ONE;
                            state_d      = FLUSH;
                        end
                    end
                endcase
            end
            default: begin
                // RUN, and MEM_WAIT once memory is ready, share one decode.
                case (prio_s)
                    MEM: begin
                        state_d = MEM_WAIT;
                        if (eff_state_s == MEM_WAIT) begin
                            wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q
                                                                  : wait_cnt_q + WAIT_ONE;
                        end else begin
                            wait_cnt_d = WAIT_ONE;
                        end
                    end
                    BR: begin
                        flush_left_d = FL_RELOAD;
                        state_d      = branch_next_s ? FLUSH : RUN;
                    end
                    default: begin
                        state_d = RUN;
                    end
                endcase
            end
        endcase
        mem_timeout_d = mem_timeout_q || (wait_cnt_d == TIMEOUT_VAL);
    end

    // Output decode: freeze and flush are never raised on the same register.
    always_comb begin
        pc_freeze_o     = 1'b0;
        if_id_freeze_o  = 1'b0;
        id_ex_freeze_o  = 1'b0;
        ex_mem_freeze_o = 1'b0;
        mem_wb_freeze_o = 1'b0;
        if_id_flush_o   = 1'b0;
        id_ex_flush_o   = 1'b0;
        case (prio_s)
            MEM: begin
                pc_freeze_o     = 1'b1;
                if_id_freeze_o  = 1'b1;
                id_ex_freeze_o  = 1'b1;
                ex_mem_freeze_o = 1'b1;
                mem_wb_freeze_o = 1'b1;
            end
            BR: begin
                if_id_flush_o = 1'b1;
                id_ex_flush_o = 1'b1;
            end
            LU: begin
                if (eff_state_s == FLUSH) begin
                    if_id_flush_o = 1'b1;
                end else begin
                    pc_freeze_o    = 1'b1;
                    if_id_freeze_o = 1'b1;
                    id_ex_flush_o  = 1'b1;
                end
            end
            default: begin
                if (eff_state_s == FLUSH) begin
                    if_id_flush_o = 1'b1;
                end else begin
                    if_id_flush_o = 1'b0;
                end
            end
        endcase
    end

    assign mem_timeout_o = mem_timeout_q;

`ifdef HAZARD_STATS_EN
    logic any_freeze_s;
    logic any_flush_s;

    assign any_freeze_s = pc_freeze_o | if_id_freeze_o | id_ex_freeze_o |
                          ex_mem_freeze_o | mem_wb_freeze_o;
    assign any_flush_s  = if_id_flush_o | id_ex_flush_o;

    hazard_sat_counter #(.W(`WORD_LEN)) u_stall_cnt (
        .clk_i (clk_i),
        .clr_i (rst_i),
        .inc_i (any_freeze_s),
        .cnt_o (stall_cnt_o)
    );

    hazard_sat_counter #(.W(`WORD_LEN)) u_flush_cnt (
        .clk_i (clk_i),
        .clr_i (rst_i),
        .inc_i (any_flush_s),
        .cnt_o (flush_cnt_o)
    );
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Directed stimulus with hand-computed expectations pushed to a scoreboard
// queue; a monitor on the falling edge pops and compares every cycle.
// DUT configuration: FLUSH_CYCLES=3, MEM_TIMEOUT=5.
// Expected vector bit order:
//   {pc_fz, if_id_fz, id_ex_fz, ex_mem_fz, mem_wb_fz, if_id_fl, id_ex_fl, timeout}
// -----------------------------------------------------------------------------
`ifdef HAZARD_STATS_EN
`ifndef WORD_LEN
`define WORD_LEN 32
`endif
`endif

module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] id_src1, id_src2, ex_dest;
    logic       id_use_src2, ex_mem_read, branch_taken, mem_busy;
    logic       pc_freeze, if_id_freeze, id_ex_freeze, ex_mem_freeze, mem_wb_freeze;
    logic       if_id_flush, id_ex_flush, mem_timeout;
`ifdef HAZARD_STATS_EN
    logic [`WORD_LEN-1:0] stall_cnt, flush_cnt;
`endif

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .REG_ADDR_W   (4),
        .FLUSH_CYCLES (3),
        .MEM_TIMEOUT  (5)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .id_src1_i       (id_src1),
        .id_src2_i       (id_src2),
        .id_use_src2_i   (id_use_src2),
        .ex_mem_read_i   (ex_mem_read),
        .ex_dest_i       (ex_dest),
        .branch_taken_i  (branch_taken),
        .mem_busy_i      (mem_busy),
        .pc_freeze_o     (pc_freeze),
        .if_id_freeze_o  (if_id_freeze),
        .id_ex_freeze_o  (id_ex_freeze),
        .ex_mem_freeze_o (ex_mem_freeze),
        .mem_wb_freeze_o (mem_wb_freeze),
        .if_id_flush_o   (if_id_flush),
        .id_ex_flush_o   (id_ex_flush),
        .mem_timeout_o   (mem_timeout)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cnt_o     (stall_cnt),
        .flush_cnt_o     (flush_cnt)
`endif
    );

    localparam logic [7:0] E_IDLE = 8'b00000_00_0;
    localparam logic [7:0] E_LU   = 8'b11000_01_0;
    localparam logic [7:0] E_BR   = 8'b00000_11_0;
    localparam logic [7:0] E_IF1  = 8'b00000_10_0;
    localparam logic [7:0] E_FRZ  = 8'b11111_00_0;
    localparam logic [7:0] E_TO   = 8'b00000_00_1;

    typedef struct {
        logic [7:0] v;
        string      name;
        bit         chk_stats;
        int         stall;
        int         flush;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // One cycle of stimulus, driven just after the rising edge, with its expectation.
    task automatic cyc(input logic r, input logic busy, input logic br,
                       input logic mrd, input logic [3:0] dst,
                       input logic [3:0] s1, input logic [3:0] s2, input logic use2,
                       input logic [7:0] ev, input string nm,
                       input bit cs, input int es, input int ef);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; mem_busy = busy; branch_taken = br; ex_mem_read = mrd;
        ex_dest = dst; id_src1 = s1; id_src2 = s2; id_use_src2 = use2;
        e.v = ev; e.name = nm; e.chk_stats = cs; e.stall = es; e.flush = ef;
        exp_q.push_back(e);
    endtask

    task automatic idle(input logic [7:0] ev, input string nm);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, ev, nm, 1'b0, 0, 0);
    endtask

    task automatic busy(input logic br, input logic [7:0] ev, input string nm);
        cyc(1'b0, 1'b1, br, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, ev, nm, 1'b0, 0, 0);
    endtask

    task automatic branch(input logic [7:0] ev, input string nm);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, ev, nm, 1'b0, 0, 0);
    endtask

    task automatic lu3(input logic [7:0] ev, input string nm);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 4'd3, 4'd0, 1'b0, ev, nm, 1'b0, 0, 0);
    endtask

    task automatic reset_cyc(input logic [7:0] ev, input string nm);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, ev, nm, 1'b0, 0, 0);
    endtask

    // Monitor: compare the presented outputs against the oldest expectation.
    always @(negedge clk) begin
        exp_t       e;
        logic [7:0] got;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {pc_freeze, if_id_freeze, id_ex_freeze, ex_mem_freeze, mem_wb_freeze,
                   if_id_flush, id_ex_flush, mem_timeout};
            n_checks++;
            if (got === e.v) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got %b expected %b", e.name, got, e.v);
            end
`ifdef HAZARD_STATS_EN
            if (e.chk_stats) begin
                n_checks++;
                if ((stall_cnt == `WORD_LEN'(e.stall)) && (flush_cnt == `WORD_LEN'(e.flush))) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s_stats: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                             e.name, stall_cnt, flush_cnt, e.stall, e.flush);
                end
            end
`endif
        end
    end

    initial begin
        rst = 1'b1; mem_busy = 1'b0; branch_taken = 1'b0; ex_mem_read = 1'b0;
        ex_dest = 4'd0; id_src1 = 4'd0; id_src2 = 4'd0; id_use_src2 = 1'b0;
        @(posedge clk);

        // Reset state and idle outputs.
        reset_cyc(E_IDLE, "reset");
        idle(E_IDLE, "idle_after_reset");

        // Load-use on src1, then natural release.
        lu3(E_LU, "lu_src1");
        idle(E_IDLE, "lu_release");
        // Register 0 never hazards.
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 1'b0, E_IDLE, "lu_r0", 1'b0, 0, 0);
        // Load-use on src2 only when src2 is read.
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 4'd1, 4'd5, 1'b1, E_LU, "lu_src2", 1'b0, 0, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 4'd1, 4'd5, 1'b0, E_IDLE, "lu_src2_unused", 1'b0, 0, 0);

        // Branch with simultaneous lu, 3-cycle window, lu ignored inside it.
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 4'd3, 4'd0, 1'b0, E_BR, "br_lu_c0", 1'b0, 0, 0);
        lu3(E_IF1, "br_c1_lu_ignored");
        idle(E_IF1, "br_c2");
        idle(E_IDLE, "br_c3_run");

        // mem_busy for 4 cycles holding a taken branch, then branch acted on.
        busy(1'b1, E_FRZ, "busy_br_1");
        busy(1'b1, E_FRZ, "busy_br_2");
        busy(1'b1, E_FRZ, "busy_br_3");
        busy(1'b1, E_FRZ, "busy_br_4");
        branch(E_BR, "busy_br_release");
        idle(E_IF1, "busy_br_fl1");
        idle(E_IF1, "busy_br_fl2");
        idle(E_IDLE, "busy_br_done");

        // Reset during a flush window returns straight to RUN.
        branch(E_BR, "rst_win_br");
        reset_cyc(E_IDLE, "rst_win_rstcycle");
        idle(E_IDLE, "rst_win_after");

        // Branch inside the window restarts it.
        branch(E_BR, "restart_br0");
        idle(E_IF1, "restart_c1");
        branch(E_BR, "restart_br1");
        idle(E_IF1, "restart_c2");
        idle(E_IF1, "restart_c3");
        idle(E_IDLE, "restart_done");

        // mem_busy inside the window freezes and holds the countdown.
        branch(E_BR, "flbusy_br");
        busy(1'b0, E_FRZ, "flbusy_frz");
        idle(E_IF1, "flbusy_c1");
        idle(E_IF1, "flbusy_c2");
        idle(E_IDLE, "flbusy_done");

        // Timeout: set on the edge closing the 5th busy cycle, sticky until reset.
        busy(1'b0, E_FRZ, "to_busy1");
        busy(1'b0, E_FRZ, "to_busy2");
        busy(1'b0, E_FRZ, "to_busy3");
        busy(1'b0, E_FRZ, "to_busy4");
        busy(1'b0, E_FRZ, "to_busy5");
        busy(1'b0, E_FRZ | E_TO, "to_busy6");
        idle(E_TO, "to_sticky");
        lu3(E_LU | E_TO, "to_lu_unaffected");
        reset_cyc(E_TO, "to_rstcycle");
        idle(E_IDLE, "to_cleared");

`ifdef HAZARD_STATS_EN
        // Two load-use stalls and one 3-cycle branch window.
        lu3(E_LU, "st_lu1");
        idle(E_IDLE, "st_gap1");
        lu3(E_LU, "st_lu2");
        idle(E_IDLE, "st_gap2");
        branch(E_BR, "st_br");
        idle(E_IF1, "st_fl1");
        idle(E_IF1, "st_fl2");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, E_IDLE, "st_final",
            1'b1, 2, 5);
`endif

        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
